simon_button_conditioner: RTL and testbench

//  Input conditioning stage directly upstream of the Simon game core.
//  - Synchronises, debounces and arbitrates the four raw player buttons (ui_in[3:0]).
//  - Delivers a clean one-hot held level, plus one-cycle press/release events.
//  - Debounce timing is in milliseconds, using the same ticks_per_milli value the

---
 rtl/simon_pkg.sv | 43 ++++
 rtl/simon_button_conditioner_if.sv | 22 ++
 rtl/simon_debounce_ch.sv | 61 ++++++
 rtl/simon_button_conditioner.sv | 120 ++++++++++++
 tb/tb_simon_button_conditioner.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon button conditioning path.
package simon_pkg;

    localparam int NUM_BTN = 4;
    localparam int OWNER_W = $clog2(NUM_BTN) + 1;

    typedef logic [NUM_BTN-1:0] btn_vec_t;
    typedef logic [OWNER_W-1:0] owner_t;

    // Out-of-range index meaning "no button owns the output".
    localparam owner_t OWNER_NONE = owner_t'(NUM_BTN);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } own_state_t;

    // Isolate the lowest set bit (two's-complement trick).
    function automatic btn_vec_t lowest_set(input btn_vec_t v);
        return v & (~v + btn_vec_t'(1));
    endfunction

    // One-hot (or zero) vector to channel index; zero maps to OWNER_NONE.
    function automatic owner_t oh_to_index(input btn_vec_t oh);
        owner_t idx;
        idx = OWNER_NONE;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (oh[i]) idx = owner_t'(i);
        end
        return idx;
    endfunction

    // Channel index to one-hot; OWNER_NONE maps to all zeros.
    function automatic btn_vec_t index_to_oh(input owner_t idx);
        btn_vec_t oh;
        oh = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (idx == owner_t'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/simon_button_conditioner_if.sv
// Button-side bundle between the raw pins / tick config and the conditioner.
interface simon_button_conditioner_if;
    import simon_pkg::*;

    logic [15:0] ticks_per_milli;
    btn_vec_t    btn_raw;
    btn_vec_t    btn_level;
    btn_vec_t    btn_press;
    btn_vec_t    btn_release;
    logic        btn_busy;

    modport master (
        output ticks_per_milli, btn_raw,
        input  btn_level, btn_press, btn_release, btn_busy
    );

    modport slave (
        input  ticks_per_milli, btn_raw,
        output btn_level, btn_press, btn_release, btn_busy
    );

endinterface

// File: rtl/simon_debounce_ch.sv
// One button channel: synchroniser chain, millisecond debounce counter and
// the debounced state flop. A new level is accepted only after it has been
// seen continuously for DEBOUNCE_MS millisecond ticks.
module simon_debounce_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_MS = 10,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ms_tick,
    input  logic btn_raw,
    output logic btn_deb
);

    localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   deb_q, deb_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign btn_deb  = deb_q;

    // Shift the (polarity-normalised) raw pin through the synchroniser.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw ^ ACTIVE_LOW};
    end

    // Count ticks while the synchronised level disagrees; any agreement restarts.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync_out == deb_q) begin
            cnt_d = '0;
        end else if (ms_tick) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync_out;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/simon_button_conditioner.sv
// Conditions the four raw Simon buttons: shared ms prescaler, per-channel
// debounce, then a single-owner arbiter producing a one-hot held level and
// one-cycle press/release events.
module simon_button_conditioner
    import simon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_MS = 10,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    simon_button_conditioner_if.slave  bus
);

    logic [15:0] presc_q, presc_d, presc_lim;
    logic        ms_tick;
    btn_vec_t    deb;
    btn_vec_t    deb_prev_q, deb_prev_d;
    btn_vec_t    rise, owner_oh;
    own_state_t  state_q, state_d;
    owner_t      owner_q, owner_d;
    btn_vec_t    level_q, level_d;
    btn_vec_t    press_q, press_d;
    btn_vec_t    release_q, release_d;
    logic        busy_q, busy_d;

    // A limit of 0 behaves like 1; ">=" lets a lowered limit wrap promptly.
    assign presc_lim = (bus.ticks_per_milli == 16'd0) ? 16'd1 : bus.ticks_per_milli;
    assign ms_tick   = (presc_q >= presc_lim - 16'd1);

    // Free-running millisecond prescaler.
    always_comb begin
        presc_d = ms_tick ? 16'd0 : presc_q + 16'd1;
    end

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
            simon_debounce_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEBOUNCE_MS (DEBOUNCE_MS),
                .ACTIVE_LOW  (ACTIVE_LOW)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .ms_tick (ms_tick),
                .btn_raw (bus.btn_raw[gi]),
                .btn_deb (deb[gi])
            );
        end
    endgenerate

    // Only fresh rises are candidates, so buttons held across an owned
    // period never get a late press.
    assign rise     = deb & ~deb_prev_q;
    assign owner_oh = index_to_oh(owner_q);

    // Owner FSM and next-cycle output values.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        deb_prev_d = deb;
        level_d    = '0;
        press_d    = '0;
        release_d  = '0;
        busy_d     = |deb;
        case (state_q)
            ST_IDLE: begin
                if (|rise) begin
                    press_d = lowest_set(rise);
                    level_d = press_d;
                    owner_d = oh_to_index(press_d);
                    state_d = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (|(owner_oh & ~deb)) begin
                    release_d = owner_oh;
                    owner_d   = OWNER_NONE;
                    state_d   = ST_IDLE;
                end else begin
                    level_d = owner_oh;
                end
            end
            default: begin
                owner_d = OWNER_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Prescaler, arbiter state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_NONE;
            deb_prev_q <= '0;
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            state_q    <= state_d;
            owner_q    <= owner_d;
            deb_prev_q <= deb_prev_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_busy    = busy_q;

endmodule

// File: tb/tb_simon_button_conditioner.sv
// Bench for simon_button_conditioner: directed scenarios plus randomized
// button activity, each cycle compared against a behavioural model.
module tb_simon_button_conditioner;

    localparam int DEB  = 3;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simon_button_conditioner_if bus ();

    simon_button_conditioner #(
        .SYNC_STAGES (SYNC),
        .DEBOUNCE_MS (DEB),
        .ACTIVE_LOW  (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [3:0] m_hist0, m_hist1, m_d, m_dprev;
    logic [3:0] m_level, m_press, m_rel;
    logic       m_busy;
    int         m_cnt [4];
    int         m_owner;
    int         m_cyc;
    int         T = 4;

    // Bookkeeping
    int ecount = 0;
    int press_cnt [4];
    int rel_cnt [4];
    int first_press_edge, last_press_edge;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, ecount);
        end
    endtask

    task automatic model_reset();
        m_hist0 = '0; m_hist1 = '0; m_d = '0; m_dprev = '0;
        m_level = '0; m_press = '0; m_rel = '0; m_busy = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_owner = -1;
        m_cyc = 0;
    endtask

    // What the outputs/state become at the coming clock edge.
    task automatic model_edge(input logic [3:0] raw);
        logic       tick;
        logic [3:0] new_d, rise;
        tick = ((m_cyc % T) == T - 1);
        m_level = '0; m_press = '0; m_rel = '0;
        rise = m_d & ~m_dprev;
        if (m_owner < 0) begin
            for (int i = 0; i < 4; i++) begin
                if (m_owner < 0 && rise[i]) begin
                    m_owner = i;
                    m_press[i] = 1'b1;
                    m_level[i] = 1'b1;
                end
            end
        end else if (!m_d[m_owner]) begin
            m_rel[m_owner] = 1'b1;
            m_owner = -1;
        end else begin
            m_level[m_owner] = 1'b1;
        end
        m_busy = |m_d;
        new_d = m_d;
        for (int i = 0; i < 4; i++) begin
            if (m_hist1[i] == m_d[i]) begin
                m_cnt[i] = 0;
            end else if (tick) begin
                m_cnt[i]++;
                if (m_cnt[i] == DEB) begin
                    new_d[i] = m_hist1[i];
                    m_cnt[i] = 0;
                end
            end
        end
        m_dprev = m_d;
        m_d = new_d;
        m_hist1 = m_hist0;
        m_hist0 = raw;
        m_cyc++;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i] = 0;
        end
        first_press_edge = -1;
        last_press_edge = -1;
    endtask

    task automatic observe();
        check_eq("level", 32'(bus.btn_level), 32'(m_level));
        check_eq("press", 32'(bus.btn_press), 32'(m_press));
        check_eq("release", 32'(bus.btn_release), 32'(m_rel));
        check_eq("busy", 32'(bus.btn_busy), 32'(m_busy));
        check_eq("level_onehot0", 32'($onehot0(bus.btn_level)), 32'd1);
        check_eq("press_rel_excl", 32'((|bus.btn_press) && (|bus.btn_release)), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (bus.btn_press[i]) begin
                press_cnt[i]++;
                if (first_press_edge < 0) first_press_edge = ecount - 1;
                last_press_edge = ecount - 1;
            end
            if (bus.btn_release[i]) rel_cnt[i]++;
        end
    endtask

    task automatic step(input logic [3:0] raw);
        @(negedge clk);
        observe();
        bus.btn_raw = raw;
        if (rst_n) begin
            model_edge(raw);
            ecount++;
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        observe();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_level", 32'(bus.btn_level), 32'd0);
        check_eq("rst_press", 32'(bus.btn_press), 32'd0);
        check_eq("rst_release", 32'(bus.btn_release), 32'd0);
        check_eq("rst_busy", 32'(bus.btn_busy), 32'd0);
    endtask

    task automatic release_reset(input logic [3:0] raw, output int rel_edge);
        @(negedge clk);
        observe();
        rst_n = 1'b1;
        T = (bus.ticks_per_milli == 16'd0) ? 1 : int'(bus.ticks_per_milli);
        bus.btn_raw = raw;
        rel_edge = ecount;
        model_edge(raw);
        ecount++;
    endtask

    initial begin
        int rel_edge, tgl_edge, lat;
        int tpm_tab [6];
        logic [3:0] raw;
        logic [3:0] flip;
        tpm_tab = '{0, 1, 2, 3, 4, 7};

        bus.ticks_per_milli = 16'd4;
        bus.btn_raw = 4'hF;
        rst_n = 1'b0;
        model_reset();
        clr_counts();

        // Reset with all buttons held
        repeat (3) step(4'hF);
        check_eq("rst_hold_level", 32'(bus.btn_level), 32'd0);
        release_reset(4'hF, rel_edge);
        repeat (30) step(4'hF);
        check_eq("rst_first_press_late", 32'(first_press_edge - rel_edge >= 11), 32'd1);
        check_eq("rst_press_bit0", 32'(press_cnt[0]), 32'd1);
        repeat (30) step(4'h0);
        $display("scenario reset_hold: first press %0d edges after release", first_press_edge - rel_edge);

        // Clean press
        clr_counts();
        repeat (40) step(4'b0100);
        repeat (30) step(4'b0000);
        check_eq("clean_press_cnt", 32'(press_cnt[2]), 32'd1);
        check_eq("clean_release_cnt", 32'(rel_cnt[2]), 32'd1);
        check_eq("clean_other_press", 32'(press_cnt[0] + press_cnt[1] + press_cnt[3]), 32'd0);
        $display("scenario clean_press: presses=%0d releases=%0d", press_cnt[2], rel_cnt[2]);

        // Bounce on bit0
        clr_counts();
        tgl_edge = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 27) tgl_edge = ecount;
            step({3'b000, 1'((k / 3) % 2)});
        end
        repeat (30) step(4'b0001);
        lat = last_press_edge - tgl_edge;
        check_eq("bounce_press_cnt", 32'(press_cnt[0]), 32'd1);
        check_eq("bounce_latency_ok", 32'(lat >= 11 && lat <= 15), 32'd1);
        repeat (30) step(4'b0000);
        $display("scenario bounce: presses=%0d latency=%0d", press_cnt[0], lat);

        // Simultaneous press
        clr_counts();
        repeat (40) step(4'b1010);
        repeat (30) step(4'b1000);
        repeat (30) step(4'b0000);
        check_eq("simul_press1", 32'(press_cnt[1]), 32'd1);
        check_eq("simul_press3", 32'(press_cnt[3]), 32'd0);
        check_eq("simul_release1", 32'(rel_cnt[1]), 32'd1);
        $display("scenario simultaneous: p1=%0d p3=%0d r1=%0d", press_cnt[1], press_cnt[3], rel_cnt[1]);

        // Overlap
        clr_counts();
        repeat (30) step(4'b0001);
        repeat (30) step(4'b0101);
        repeat (30) step(4'b0100);
        check_eq("ovl_busy", 32'(bus.btn_busy), 32'd1);
        check_eq("ovl_level", 32'(bus.btn_level), 32'd0);
        repeat (30) step(4'b0000);
        check_eq("ovl_press0", 32'(press_cnt[0]), 32'd1);
        check_eq("ovl_press2", 32'(press_cnt[2]), 32'd0);
        $display("scenario overlap: p0=%0d p2=%0d", press_cnt[0], press_cnt[2]);

        // Reset mid-hold
        repeat (30) step(4'b0001);
        check_eq("midrst_level_before", 32'(bus.btn_level), 32'd1);
        assert_reset();
        clr_counts();
        repeat (3) step(4'b0001);
        release_reset(4'b0001, rel_edge);
        repeat (30) step(4'b0001);
        check_eq("midrst_no_release", 32'(rel_cnt[0]), 32'd0);
        check_eq("midrst_press", 32'(press_cnt[0]), 32'd1);
        repeat (30) step(4'b0000);
        $display("scenario reset_mid_hold: presses=%0d releases=%0d", press_cnt[0], rel_cnt[0]);

        // Randomized activity with varying ticks_per_milli
        for (int r = 0; r < 6; r++) begin
            assert_reset();
            bus.ticks_per_milli = 16'(tpm_tab[$urandom_range(0, 5)]);
            raw = 4'($urandom_range(0, 15));
            repeat (2) step(raw);
            release_reset(raw, rel_edge);
            clr_counts();
            for (int c = 0; c < 400; c++) begin
                flip = '0;
                for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 11) == 0);
                raw = raw ^ flip;
                step(raw);
            end
            $display("scenario random %0d: tpm=%0d presses=%0d/%0d/%0d/%0d", r, bus.ticks_per_milli,
                     press_cnt[0], press_cnt[1], press_cnt[2], press_cnt[3]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
